// File: rtl/mul_iter_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
//   state_e : controller states (IDLE waits for operands, CALC iterates, DONE holds result)
//   k_legal : true for the supported radix digit widths
package mul_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Supported multiplier bits consumed per CALC cycle.
    function automatic bit k_legal(input int unsigned k);
        return (k == 1) || (k == 2) || (k == 4);
    endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One combinational radix-2^K step: acc_nxt = acc + mcand * digit.
//   acc     in  2N  running partial sum
//   mcand   in  2N  multiplicand already shifted to the current digit position
//   digit   in  K   multiplier bits consumed this step
//   acc_nxt out 2N  updated partial sum
module mul_iter_step #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 1
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] mcand,
    input  logic [K-1:0]   digit,
    output logic [2*N-1:0] acc_nxt
);

    // Shift-add over the K digit bits; the product never exceeds 2N bits.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < int'(K); i++) begin
            if (digit[i]) begin
                acc_nxt = acc_nxt + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-2^K shift-add multiplier with ready/valid on both sides.
// Operands are reduced to magnitudes at capture; the sign is re-applied once
// on the final accumulator as it is loaded into the output register.
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   i_a      in   N   multiplicand (sampled on input handshake)
//   i_b      in   N   multiplier (sampled on input handshake)
//   i_signed in   1   1: two's-complement operands
//   i_vld    in   1   operand valid
//   o_rdy    out  1   ready for operands (IDLE and not in reset)
//   o_res    out  2N  product, valid while o_vld
//   o_vld    out  1   result valid
//   i_rdy    in   1   downstream ready for result
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned K          = 1,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    input  logic           i_signed,
    input  logic           i_vld,
    output logic           o_rdy,
    output logic [2*N-1:0] o_res,
    output logic           o_vld,
    input  logic           i_rdy
);

    localparam int unsigned W2    = 2 * N;
    localparam int unsigned STEPS = N / K;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    generate
        if (!k_legal(K) || (N % K) != 0 || N < 4) begin : g_bad_param
            $error("mul_iter: illegal parameters (K must be 1, 2 or 4, N %% K == 0, N >= 4)");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [W2-1:0]    res_q, res_d;
    logic             vld_q, vld_d;
    logic [W2-1:0]    acc_step;
    logic             last_step;

    // |x| for signed operands; -2^(N-1) maps to 2^(N-1), which still fits N bits.
    function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic s);
        return (s && x[N-1]) ? (~x + N'(1)) : x;
    endfunction

    mul_iter_step #(
        .N (N),
        .K (K)
    ) u_step (
        .acc     (acc_q),
        .mcand   (mcand_q),
        .digit   (mplier_q[K-1:0]),
        .acc_nxt (acc_step)
    );

    assign o_rdy = (state_q == ST_IDLE) && !rst;
    assign o_res = res_q;
    assign o_vld = vld_q;

    // Early exit looks at the multiplier bits that would remain after this step.
    assign last_step = (cnt_q == CNT_W'(1)) ||
                       (EARLY_EXIT && ((mplier_q >> K) == '0));

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        res_d    = res_q;
        vld_d    = vld_q;

        case (state_q)
            ST_IDLE: begin
                if (i_vld && o_rdy) begin
                    neg_d    = i_signed & (i_a[N-1] ^ i_b[N-1]);
                    acc_d    = '0;
                    mcand_d  = W2'(mag(i_a, i_signed));
                    mplier_d = mag(i_b, i_signed);
                    cnt_d    = CNT_W'(STEPS);
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << K;
                mplier_d = mplier_q >> K;
                cnt_d    = cnt_q - CNT_W'(1);
                if (last_step) begin
                    res_d   = neg_q ? (~acc_step + W2'(1)) : acc_step;
                    vld_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_rdy) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: three instances (K=1, K=4, K=1 with early exit) share
// clock, reset and operand buses; each has its own valid/ready lines.
module tb_mul_iter;

    logic        clk;
    logic        rst;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        i_signed;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  ovld;
    logic [2:0]  ordy;
    logic [31:0] res0, res1, res2;

    int n_cmp = 0;
    int n_bad = 0;

    mul_iter #(.N(16), .K(1), .EARLY_EXIT(1'b0)) u_k1 (
        .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_signed(i_signed),
        .i_vld(vld[0]), .o_rdy(ordy[0]), .o_res(res0), .o_vld(ovld[0]), .i_rdy(rdy[0])
    );

    mul_iter #(.N(16), .K(4), .EARLY_EXIT(1'b0)) u_k4 (
        .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_signed(i_signed),
        .i_vld(vld[1]), .o_rdy(ordy[1]), .o_res(res1), .o_vld(ovld[1]), .i_rdy(rdy[1])
    );

    mul_iter #(.N(16), .K(1), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_signed(i_signed),
        .i_vld(vld[2]), .o_rdy(ordy[2]), .o_res(res2), .o_vld(ovld[2]), .i_rdy(rdy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] get_res(input int idx);
        case (idx)
            0:       return res0;
            1:       return res1;
            default: return res2;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        logic signed [31:0] sa, sb;
        if (s) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            return sa * sb;
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    // Cycles from input handshake edge (counted as 1) to the edge raising o_vld.
    function automatic int ref_lat(input int idx, input logic [15:0] b, input logic s);
        int          k;
        int          steps;
        logic [15:0] m;
        k = (idx == 1) ? 4 : 1;
        if (idx != 2) return 16 / k + 1;
        m = (s && b[15]) ? (~b + 16'd1) : b;
        steps = 0;
        while (m != 16'd0) begin
            m = m >> k;
            steps++;
        end
        if (steps == 0) steps = 1;
        return steps + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; during 'hold' cycles of backpressure i_vld is
    // asserted with other operands, which the busy block must ignore.
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input int hold,
                         output logic [31:0] r, output int lat);
        bit stable_ok;
        @(negedge clk);
        i_a = a; i_b = b; i_signed = s; vld[idx] = 1'b1;
        @(posedge clk); #1;
        vld[idx] = 1'b0; i_a = 'x; i_b = 'x; i_signed = 'x;
        lat = 1;
        while (!ovld[idx] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("o_vld timeout", 32'(ovld[idx]), 32'd1);
        r = get_res(idx);
        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            i_a = ~a; i_b = ~b; i_signed = ~s; vld[idx] = 1'b1;
            @(posedge clk); #1;
            if (!ovld[idx] || get_res(idx) !== r || ordy[idx]) stable_ok = 1'b0;
        end
        vld[idx] = 1'b0;
        if (hold > 0) check("hold stable", 32'(stable_ok), 32'd1);
        rdy[idx] = 1'b1;
        @(posedge clk); #1;
        rdy[idx] = 1'b0;
        check("release vld/rdy", {30'd0, ovld[idx], ordy[idx]}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic [15:0] a, b;
        logic        s;
        int          idx;
        bit          quiet;

        vecs[0]  = '{0, 16'd255,  16'd255,  1'b0, 32'd65025,     17};
        vecs[1]  = '{0, 16'hFFFD, 16'd7,    1'b1, 32'hFFFF_FFEB, 17};
        vecs[2]  = '{0, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 17};
        vecs[3]  = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 17};
        vecs[4]  = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 17};
        vecs[5]  = '{0, 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 17};
        vecs[6]  = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 5};
        vecs[7]  = '{1, 16'd255,  16'd255,  1'b0, 32'd65025,     5};
        vecs[8]  = '{1, 16'hFFFD, 16'd7,    1'b1, 32'hFFFF_FFEB, 5};
        vecs[9]  = '{2, 16'd1234, 16'd0,    1'b0, 32'd0,         2};
        vecs[10] = '{2, 16'd1234, 16'd1,    1'b0, 32'd1234,      2};
        vecs[11] = '{2, 16'd3,    16'h8000, 1'b0, 32'h0001_8000, 17};
        vecs[12] = '{2, 16'd5,    16'hFFFF, 1'b1, 32'hFFFF_FFFB, 2};
        vecs[13] = '{2, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 17};
        vecs[14] = '{2, 16'd7,    16'd2,    1'b0, 32'd14,        3};

        rst = 1'b1; vld = '0; rdy = '0;
        i_a = '0; i_b = '0; i_signed = 1'b0;
        #1;
        check("reset o_vld/o_rdy", {30'd0, ovld[0], ordy[0]}, 32'd0);
        check("reset o_res", res0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset o_rdy", {29'd0, ordy}, 32'd7);

        // Directed table.
        foreach (vecs[i]) begin
            do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].s, 0, r, lat);
            check($sformatf("vec%0d res", i), r, vecs[i].res);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held 10 cycles with competing i_vld.
        do_op(0, 16'd100, 16'd3, 1'b0, 10, r, lat);
        check("backpressure res", r, 32'd300);
        do_op(0, 16'd6, 16'd7, 1'b0, 0, r, lat);
        check("after backpressure res", r, 32'd42);

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        i_a = 16'd9; i_b = 16'd9; i_signed = 1'b0; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("mid-op reset o_vld/o_rdy", {30'd0, ovld[0], ordy[0]}, 32'd0);
        check("mid-op reset o_res", res0, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("after reset o_vld/o_rdy", {30'd0, ovld[0], ordy[0]}, 32'd1);
        quiet = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (ovld[0] || !ordy[0]) quiet = 1'b0;
        end
        check("aborted op silent", {31'd0, quiet}, 32'd1);
        do_op(0, 16'd9, 16'd9, 1'b0, 0, r, lat);
        check("op after reset res", r, 32'd81);
        check("op after reset latency", 32'(lat), 32'd17);

        // Random operations against the reference model.
        for (int i = 0; i < 1000; i++) begin
            idx = i % 3;
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            if (i % 11 == 0) a = 16'h8000;
            if (i % 13 == 0) b = 16'h8000;
            if (i % 17 == 0) b = 16'($urandom_range(0, 3));
            do_op(idx, a, b, s, int'($urandom_range(0, 3)), r, lat);
            check($sformatf("rand%0d res a=%h b=%h s=%b", i, a, b, s), r, ref_mul(a, b, s));
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(idx, b, s)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
